// File: rtl/phy_tx_arbiter.sv
// phy_tx_arbiter: packet-granular round-robin arbiter sharing the PHY
// transmit datapath between two AXI-Stream requesters.
module phy_tx_arbiter #(
  parameter int P_IFG = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_gt_tx_done,
  input  logic [31:0] i_s0_axis_data,
  input  logic [3:0]  i_s0_axis_keep,
  input  logic        i_s0_axis_valid,
  input  logic        i_s0_axis_last,
  output logic        o_s0_axis_ready,
  input  logic [31:0] i_s1_axis_data,
  input  logic [3:0]  i_s1_axis_keep,
  input  logic        i_s1_axis_valid,
  input  logic        i_s1_axis_last,
  output logic        o_s1_axis_ready,
  output logic [31:0] o_m_axis_data,
  output logic [3:0]  o_m_axis_keep,
  output logic        o_m_axis_valid,
  output logic        o_m_axis_last,
  input  logic        i_m_axis_ready,
  output logic [1:0]  o_grant,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  localparam logic [3:0] GAP_LOAD =
    (P_IFG > 0) ? 4'(P_IFG - 1) : 4'd0;

  state_t     state;
  logic       rr_ptr;
  logic [3:0] gap_cnt;
  logic       any_req;
  logic       win;
  logic       xfer_last;

  assign any_req = i_s0_axis_valid | i_s1_axis_valid;

  // rr_ptr only matters on a tie; a lone requester always wins
  assign win = (i_s0_axis_valid & i_s1_axis_valid)
             ? rr_ptr : i_s1_axis_valid;

  assign xfer_last = o_m_axis_valid & i_m_axis_ready
                   & o_m_axis_last;

  always_comb begin
    o_m_axis_data   = '0;
    o_m_axis_keep   = '0;
    o_m_axis_valid  = 1'b0;
    o_m_axis_last   = 1'b0;
    o_s0_axis_ready = 1'b0;
    o_s1_axis_ready = 1'b0;
    if (state == S_SEND) begin
      unique case (1'b1)
        o_grant[1]: begin
          o_m_axis_data   = i_s1_axis_data;
          o_m_axis_keep   = i_s1_axis_keep;
          o_m_axis_valid  = i_s1_axis_valid;
          o_m_axis_last   = i_s1_axis_last;
          o_s1_axis_ready = i_m_axis_ready;
        end
        o_grant[0]: begin
          o_m_axis_data   = i_s0_axis_data;
          o_m_axis_keep   = i_s0_axis_keep;
          o_m_axis_valid  = i_s0_axis_valid;
          o_m_axis_last   = i_s0_axis_last;
          o_s0_axis_ready = i_m_axis_ready;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= S_IDLE;
      rr_ptr  <= 1'b0;
      gap_cnt <= 4'd0;
      o_grant <= 2'b00;
      o_busy  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_gt_tx_done && any_req) begin
            state   <= S_SEND;
            o_grant <= win ? 2'b10 : 2'b01;
            o_busy  <= 1'b1;
          end
        end
        S_SEND: begin
          if (xfer_last) begin
            rr_ptr  <= ~o_grant[1];
            o_grant <= 2'b00;
            if (P_IFG > 0) begin
              state   <= S_GAP;
              gap_cnt <= GAP_LOAD;
            end else begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == 4'd0) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
